// File: rtl/enigma_pkg.sv
// Shared types and widths for the enigma C-channel arbiter: flit layout,
// flit-table entry states and grant-source codes.
package enigma_pkg;
  localparam int ID_W  = 6;
  localparam int PL_W  = 128;
  localparam int QOS_W = 2;
  localparam int N_ENT = 1 << ID_W;

  typedef struct packed {
    logic [PL_W-1:0]  payload;
    logic [ID_W-1:0]  id;
    logic [QOS_W-1:0] qos;
  } flit_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    HELD   = 2'd1,
    ISSUED = 2'd2
  } ent_state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_RPL  = 2'd1;
  localparam logic [1:0] SRC_A    = 2'd2;
  localparam logic [1:0] SRC_B    = 2'd3;
endpackage

// File: rtl/enigma_arb_pick.sv
// Combinational grant selection: replay (lowest index) first, then A vs B by
// starvation override, qos, and finally the round-robin pointer.
module enigma_arb_pick
  import enigma_pkg::*;
(
  input  logic              en_i,
  input  logic [N_ENT-1:0]  rpl_i,
  input  logic              elig_a_i,
  input  logic              elig_b_i,
  input  logic [QOS_W-1:0]  qos_a_i,
  input  logic [QOS_W-1:0]  qos_b_i,
  input  logic              rr_i,
  input  logic              starve_a_i,
  input  logic              starve_b_i,
  input  logic [ID_W-2:0]   id_a_i,
  input  logic [ID_W-2:0]   id_b_i,
  output logic [1:0]        src_o,
  output logic [ID_W-1:0]   id_o
);
  logic            rpl_hit;
  logic [ID_W-1:0] rpl_id;
  logic            pick_a;

  always_comb begin
    rpl_hit = 1'b0;
    rpl_id  = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (rpl_i[i]) begin
        rpl_hit = 1'b1;
        rpl_id  = ID_W'(i);
      end
    end
  end

  // Only consulted when both ports are eligible; rr_i low means A's turn.
  always_comb begin
    if (starve_a_i)               pick_a = 1'b1;
    else if (starve_b_i)          pick_a = 1'b0;
    else if (qos_a_i != qos_b_i)  pick_a = (qos_a_i > qos_b_i);
    else                          pick_a = !rr_i;
  end

  always_comb begin
    src_o = SRC_NONE;
    id_o  = '0;
    if (en_i) begin
      if (rpl_hit) begin
        src_o = SRC_RPL;
        id_o  = rpl_id;
      end else if (elig_a_i && (pick_a || !elig_b_i)) begin
        src_o = SRC_A;
        id_o  = {1'b0, id_a_i};
      end else if (elig_b_i) begin
        src_o = SRC_B;
        id_o  = {1'b1, id_b_i};
      end
    end
  end
endmodule

// File: rtl/enigma_arb.sv
// Two-port flit arbiter with a 64-entry in-flight table and conflict replay,
// driving a single registered C channel.
module enigma_arb
  import enigma_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PL_W-1:0]   payload_a,
  input  logic [ID_W-2:0]   id_a,
  input  logic [QOS_W-1:0]  qos_a,
  input  logic              valid_a,
  output logic              ready_a,
  input  logic [PL_W-1:0]   payload_b,
  input  logic [ID_W-2:0]   id_b,
  input  logic [QOS_W-1:0]  qos_b,
  input  logic              valid_b,
  output logic              ready_b,
  output logic [PL_W-1:0]   payload_c,
  output logic [ID_W-1:0]   id_c,
  output logic [QOS_W-1:0]  qos_c,
  output logic              valid_c,
  input  logic              ready_c,
  input  logic              release_c,
  input  logic              conflict_c,
  input  logic [ID_W-1:0]   releaseid_c,
  output logic [6:0]        outstanding,
  output logic              proto_err
);
  localparam int CNT_W = 8;

  ent_state_e       st_q [N_ENT];
  logic [PL_W-1:0]  pl_q [N_ENT];
  logic [QOS_W-1:0] qs_q [N_ENT];
  logic [N_ENT-1:0] rpl_q;
  flit_t            out_q;
  logic             vld_q, rr_q, err_q;
  logic [CNT_W-1:0] lost_a_q, lost_b_q;
  logic [6:0]       outst_q;

  logic [ID_W-1:0]  idx_a, idx_b, gnt_id;
  logic [1:0]       src;
  logic             elig_a, elig_b, take, hs, rsp, rsp_ok, acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign idx_a  = {1'b0, id_a};
  assign idx_b  = {1'b1, id_b};
  assign elig_a = valid_a && (st_q[idx_a] == FREE);
  assign elig_b = valid_b && (st_q[idx_b] == FREE);
  assign take   = rst_n && (!vld_q || ready_c);
  assign hs     = vld_q && ready_c;
  assign rsp    = release_c || conflict_c;
  // A response in the same cycle as its own handshake still sees HELD here.
  assign rsp_ok = (release_c ^ conflict_c) && (st_q[releaseid_c] == ISSUED);
  assign acc    = (src == SRC_A) || (src == SRC_B);

  enigma_arb_pick u_pick (
    .en_i       (take),
    .rpl_i      (rpl_q),
    .elig_a_i   (elig_a),
    .elig_b_i   (elig_b),
    .qos_a_i    (qos_a),
    .qos_b_i    (qos_b),
    .rr_i       (rr_q),
    .starve_a_i (lost_a_q >= CNT_W'(STARVE_LIM)),
    .starve_b_i (lost_b_q >= CNT_W'(STARVE_LIM)),
    .id_a_i     (id_a),
    .id_b_i     (id_b),
    .src_o      (src),
    .id_o       (gnt_id)
  );

  assign ready_a     = (src == SRC_A);
  assign ready_b     = (src == SRC_B);
  assign valid_c     = vld_q;
  assign payload_c   = out_q.payload;
  assign id_c        = out_q.id;
  assign qos_c       = out_q.qos;
  assign outstanding = outst_q;
  assign proto_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) st_q[i] <= FREE;
      rpl_q    <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
      rr_q     <= 1'b0;
      lost_a_q <= '0;
      lost_b_q <= '0;
      err_q    <= 1'b0;
      outst_q  <= '0;
    end else begin
      if (hs) st_q[out_q.id] <= ISSUED;
      if (rsp_ok) begin
        st_q[releaseid_c] <= release_c ? FREE : HELD;
        if (conflict_c) rpl_q[releaseid_c] <= 1'b1;
      end else if (rsp) begin
        err_q <= 1'b1;
      end
      outst_q <= outst_q + 7'(acc) - 7'(rsp_ok && release_c);
      if (src != SRC_NONE) vld_q <= 1'b1;
      else if (hs)         vld_q <= 1'b0;
      case (src)
        SRC_RPL: begin
          out_q         <= '{pl_q[gnt_id], gnt_id, qs_q[gnt_id]};
          rpl_q[gnt_id] <= 1'b0;
        end
        SRC_A: begin
          st_q[idx_a] <= HELD;
          out_q       <= '{payload_a, idx_a, qos_a};
          lost_a_q    <= '0;
          rr_q        <= 1'b1;
          if (elig_b) lost_b_q <= sat_inc(lost_b_q);
        end
        SRC_B: begin
          st_q[idx_b] <= HELD;
          out_q       <= '{payload_b, idx_b, qos_b};
          lost_b_q    <= '0;
          rr_q        <= 1'b0;
          if (elig_a) lost_a_q <= sat_inc(lost_a_q);
        end
        default: ;
      endcase
    end
  end

  // Stored flit contents; only the entry state needs clearing on reset.
  always_ff @(posedge clk) begin
    if (src == SRC_A) begin
      pl_q[idx_a] <= payload_a;
      qs_q[idx_a] <= qos_a;
    end else if (src == SRC_B) begin
      pl_q[idx_b] <= payload_b;
      qs_q[idx_b] <= qos_b;
    end
  end
endmodule
